// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detectors.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2
   } state_e;

   function automatic int len_w_f(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Configuration, serial stream and event bundle of the parametrised detector.
interface seq_detect_param_if
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = len_w_f(MAX_LEN);

   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               seq;
   logic               seq_valid;
   logic               tick;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;
   logic               armed;
   logic               cfg_err;

   modport master (
      output cfg_load, cfg_pattern, cfg_len, cfg_overlap, seq, seq_valid,
      input  tick, match_cnt, cnt_sat, armed, cfg_err
   );

   modport slave (
      input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, seq, seq_valid,
      output tick, match_cnt, cnt_sat, armed, cfg_err
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky "reached all-ones" flag.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);
   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else begin
         if (inc && !(&cnt_q)) cnt_d = cnt_q + W'(1);
         if (&cnt_d) sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;
endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap control.
// state | meaning
// IDLE  | no valid configuration, stream ignored
// FILL  | fewer than len bits collected since load or last non-overlap match
// ARMED | history holds len bits, every valid bit can complete a match
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8
) (
   input logic              clk,
   input logic              rst,
   seq_detect_param_if.slave bus
);
   localparam int LEN_W = len_w_f(MAX_LEN);

   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               tick_q, tick_d;
   logic               armed_q, armed_d;
   logic               cfg_err_q, cfg_err_d;

   logic               cfg_ok;
   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   fill_inc;
   logic               hit;
   logic               cnt_clr;
   logic               cnt_inc;

   always_comb begin
      cfg_ok     = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= MAX_LEN);
      hist_shift = {hist_q[MAX_LEN-2:0], bus.seq};
      for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len_q));
      fill_inc   = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
      hit        = (((hist_shift ^ pattern_q) & len_mask) == '0) && (fill_inc >= len_q);
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      armed_d   = armed_q;
      tick_d    = 1'b0;
      cfg_err_d = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      // A load pre-empts any bit presented in the same cycle.
      if (bus.cfg_load) begin
         if (cfg_ok) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            armed_d   = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = FILL;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (bus.seq_valid && state_q != IDLE) begin
         hist_d = hist_shift;
         fill_d = fill_inc;
         if (hit) begin
            tick_d  = 1'b1;
            cnt_inc = 1'b1;
            if (overlap_q) begin
               state_d = ARMED;
            end else begin
               fill_d  = '0;
               state_d = FILL;
            end
         end else begin
            state_d = (fill_inc == len_q) ? ARMED : FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         hist_q    <= '0;
         fill_q    <= '0;
         tick_q    <= 1'b0;
         armed_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         tick_q    <= tick_d;
         armed_q   <= armed_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (bus.match_cnt),
      .sat (bus.cnt_sat)
   );

   assign bus.tick    = tick_q;
   assign bus.armed   = armed_q;
   assign bus.cfg_err = cfg_err_q;
endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Runtime-configurable serial bit-pattern detector, the parametrised successor to the team's fixed-pattern detectors. It accepts one serial bit per valid cycle and compares the most recent `cfg_len` bits against a loadable pattern of up to `MAX_LEN` bits. It supports overlapping and non-overlapping match modes, emits a registered one-cycle `tick` per match, and keeps a saturating match count. It sits between the serial front end and the control logic that consumes detection events.

## Interface
- `MAX_LEN`, default 16: maximum pattern length in bits; must be ≥ 2.
- `CNT_W`, default 8: width of the match counter.
- `LEN_W`, derived as $clog2(MAX_LEN+1): width of the length field. Not user-set.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_load`  in  1  loads `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern bits. Bit [cfg_len-1] is the first bit received; bit [0] is the last.
- `cfg_len`  in  LEN_W  pattern length; valid range 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `seq`  in  1  serial data bit.
- `seq_valid`  in  1  `seq` is sampled only when this is high.
- `tick`  out  1  one-cycle match pulse, registered.
- `match_cnt`  out  CNT_W  saturating count of matches since the last load or reset.
- `cnt_sat`  out  1  sticky flag: `match_cnt` has reached its maximum.
- `armed`  out  1  a valid configuration is loaded.
- `cfg_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Internal state:
  - history shift register `hist[MAX_LEN-1:0]`; on each valid bit, `hist <= {hist[MAX_LEN-2:0], seq}`.
  - fill counter `fill` (LEN_W bits), saturating at `len`.
- FSM states:
  - IDLE: no valid configuration.
  - FILL: `fill < len`.
  - ARMED: `fill == len`.
- Transitions:
  - From any state, an accepted load goes to FILL.
  - FILL goes to ARMED when `fill` reaches `len`.
  - In ARMED, a match with `overlap=0` returns to FILL with `fill=0`.
  - In ARMED, a match with `overlap=1` stays in ARMED.
- Match condition: a valid bit arrives, the post-shift `hist[len-1:0] == pattern[len-1:0]`, and post-shift fill ≥ `len`. Bits above `len-1` are don't-care.
- Load with `1 ≤ cfg_len ≤ MAX_LEN`:
  - latch pattern, len and overlap;
  - clear `hist`, `fill`, `match_cnt` and `cnt_sat`;
  - set `armed=1`.
- Load with `cfg_len == 0` or `cfg_len > MAX_LEN`:
  - configuration and all state are unchanged;
  - `cfg_err` pulses for one cycle.
- `cfg_load` and `seq_valid` in the same cycle: the load wins and the bit is discarded.
- When `seq_valid` is low, `hist`, `fill` and state hold, and `tick` is 0.
- In IDLE, bits are ignored and `tick` is never asserted.
- On each match, `match_cnt` increments. At all-ones it holds its value and `cnt_sat` sets. `cnt_sat` clears only on reset or an accepted load.
- `len == 1` is legal: every valid bit equal to `pattern[0]` matches.

## Timing
- Reset values:
  - `tick=0`, `match_cnt=0`, `cnt_sat=0`, `armed=0`, `cfg_err=0`;
  - `hist=0`, `fill=0`, pattern=0, len=0, overlap=0;
  - state IDLE.
- Reset mid-stream discards everything, including the configuration. A reload is required before any further detection.
- `tick` latency: high in the cycle immediately after the edge that samples the completing bit. It lasts one cycle.
- `match_cnt` updates on the same edge that raises `tick`.
- Back-to-back matches (overlap, `len=1`) raise `tick` on consecutive cycles.
- `armed` and `cfg_err` change on the edge that samples `cfg_load`.
- Stream bits can be accepted starting the cycle after a load.

## Structure
- Shared package `seq_det_pkg` holds:
  - the state enum {IDLE, FILL, ARMED};
  - a function computing LEN_W from MAX_LEN.
- One sub-module: `sat_counter` (parameter W; inputs `clk`, `rst`, `clr`, `inc`; outputs `cnt`, `sat`). It implements `match_cnt` and `cnt_sat`, and is reusable by other detectors.
- The top level holds the configuration registers, the history register, the fill counter, the FSM and the compare logic.

## Test plan
- Load 7'b1101100 with `len=7` and `overlap=1`, then send 1101100 1101100 continuously → `tick` rises after bits 7 and 14, `match_cnt=2`.
- Load 4'b1010 with `len=4`, then send 1010101:
  - `overlap=1` → ticks after bits 4 and 6, `match_cnt=2`;
  - `overlap=0` → tick after bit 4 only, `match_cnt=1`.
- `CNT_W=2` with pattern 1 (`len=1`), send five 1s → five ticks on consecutive cycles; `match_cnt` stops at 3; `cnt_sat=1` from the third match on.
- With `armed=1` (pattern 1010, `len=4`), load `cfg_len=0` and then `cfg_len=MAX_LEN+1` → `cfg_err` pulses each time; `armed` stays 1; a subsequent 1010 still ticks.
- Pattern 1101100: deassert `seq_valid` for 3 cycles between every bit → exactly one tick, one cycle after the 7th valid bit.
- Pattern 1101100: assert `rst` after bit 6, then send the final 0 and repeat the full pattern → no tick and `armed=0`. After a reload, the full pattern ticks once.
